uart_port_bridge: RTL and testbench

//  Byte-level UART peripheral on the downstream side of the multi-core top's uart_* port.

---
 rtl/uart_port_bridge_pkg.sv | 38 +++
 rtl/uart_port_bridge_rx_fifo.sv | 53 +++++
 rtl/uart_port_bridge.sv | 216 +++++++++++++++++++++
 tb/tb_uart_port_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_port_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_port_bridge_pkg : register map, FSM encodings and status packing      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package uart_port_bridge_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV_LO = 2'd2;
  localparam logic [1:0] ADDR_DIV_HI = 2'd3;

  localparam int ST_TX_READY  = 0;
  localparam int ST_RX_AVAIL  = 1;
  localparam int ST_RX_FULL   = 2;
  localparam int ST_OVERRUN   = 3;
  localparam int ST_FRAME_ERR = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  function automatic logic [DATA_W-1:0] pack_status(input logic frame_err, input logic overrun,
                                                    input logic rx_full, input logic rx_avail,
                                                    input logic tx_ready);
    logic [DATA_W-1:0] s;
    s               = '0;
    s[ST_TX_READY]  = tx_ready;
    s[ST_RX_AVAIL]  = rx_avail;
    s[ST_RX_FULL]   = rx_full;
    s[ST_OVERRUN]   = overrun;
    s[ST_FRAME_ERR] = frame_err;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_port_bridge_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_port_bridge_rx_fifo : synchronous RX byte FIFO, pointer-MSB wrap      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_port_bridge_rx_fifo
  import uart_port_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overrun_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count;
  logic              do_push, do_pop;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign empty_o   = (count == '0);
  assign full_o    = (count == FULL_CNT);
  assign do_pop    = pop_i && !empty_o;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_push   = push_i && (!full_o || do_pop);
  assign overrun_o = push_i && full_o && !do_pop;
  assign head_o    = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_port_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_port_bridge : 8N1 UART with 2-bit register port, RX FIFO, baud divisor|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_port_bridge
  import uart_port_bridge_pkg::*;
#(
  parameter int CLK_DIV  = 434,
  parameter int DIV_W    = 16,
  parameter int RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rd,
  input  logic              uart_wr,
  input  logic [1:0]        uart_addr,
  input  logic [DATA_W-1:0] uart_din,
  output logic [DATA_W-1:0] uart_dout,
  output logic [DATA_W-1:0] uart_dout1,
  input  logic              rxd,
  output logic              txd
);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [DIV_W-1:0]  div_q, div_d, div_eff;
  logic [15:0]       div_ext, div_wr;
  logic [DATA_W-1:0] dout_q, dout_d, rd_data, status;
  logic              overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic              status_rd, tx_load;

  tx_state_e         tx_state_q;
  logic [DIV_W-1:0]  tx_cnt_q, tx_div_q;
  logic [2:0]        tx_bit_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic              txd_q;

  rx_state_e         rx_state_q;
  logic [1:0]        rx_sync_q;
  logic              rx_prev_q, rx_s;
  logic [DIV_W-1:0]  rx_cnt_q, rx_div_q;
  logic [2:0]        rx_bit_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic              rx_push_q, rx_ferr_q;

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty, fifo_full, fifo_overrun;

  assign div_eff    = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
  assign div_ext    = 16'(div_q);
  assign rx_s       = rx_sync_q[1];
  assign status     = pack_status(frame_err_q, overrun_q, fifo_full, !fifo_empty,
                                  tx_state_q == TX_IDLE);
  assign status_rd  = uart_rd && (uart_addr == ADDR_STATUS);
  assign tx_load    = uart_wr && (uart_addr == ADDR_DATA) && (tx_state_q == TX_IDLE);
  assign uart_dout  = dout_q;
  assign uart_dout1 = status;
  assign txd        = txd_q;

  uart_port_bridge_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (rx_push_q),
    .din_i     (rx_shift_q),
    .pop_i     (uart_rd && (uart_addr == ADDR_DATA)),
    .head_o    (fifo_head),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .overrun_o (fifo_overrun)
  );

  always_comb begin
    case (uart_addr)
      ADDR_DATA:   rd_data = fifo_head;
      ADDR_STATUS: rd_data = status;
      ADDR_DIV_LO: rd_data = div_ext[7:0];
      default:     rd_data = div_ext[15:8];
    endcase
    dout_d = uart_rd ? rd_data : dout_q;

    div_wr = div_ext;
    if (uart_wr && uart_addr == ADDR_DIV_LO) div_wr = {div_ext[15:8], uart_din};
    if (uart_wr && uart_addr == ADDR_DIV_HI) div_wr = {uart_din, div_ext[7:0]};
    div_d = DIV_W'(div_wr);

    // A new error on the clearing edge wins so no event is lost.
    overrun_d   = (overrun_q && !status_rd) || fifo_overrun;
    frame_err_d = (frame_err_q && !status_rd) || rx_ferr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q      <= '0;
      div_q       <= DIV_RST;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      div_q       <= div_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_RST;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else if (tx_state_q == TX_IDLE) begin
      if (tx_load) begin
        tx_state_q <= TX_START;
        tx_cnt_q   <= '0;
        tx_div_q   <= div_eff;
        tx_bit_q   <= '0;
        tx_shift_q <= uart_din;
        txd_q      <= 1'b0;
      end
    end else if (tx_cnt_q != tx_div_q - DIV_ONE) begin
      tx_cnt_q <= tx_cnt_q + DIV_ONE;
    end else begin
      tx_cnt_q <= '0;
      case (tx_state_q)
        TX_START: begin
          tx_state_q <= TX_DATA;
          txd_q      <= tx_shift_q[0];
        end
        TX_DATA: begin
          if (tx_bit_q == 3'd7) begin
            tx_state_q <= TX_STOP;
            txd_q      <= 1'b1;
          end else begin
            tx_bit_q   <= tx_bit_q + 3'd1;
            tx_shift_q <= tx_shift_q >> 1;
            txd_q      <= tx_shift_q[1];
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          txd_q      <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_RST;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_push_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rxd};
      rx_prev_q <= rx_s;
      rx_push_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
            rx_div_q   <= div_eff;
            rx_bit_q   <= '0;
          end
        end
        RX_START: begin
          // Mid-start sample; a line already back high was only a glitch.
          if (rx_cnt_q == (rx_div_q >> 1) - DIV_ONE) begin
            rx_cnt_q   <= '0;
            rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + DIV_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == rx_div_q - DIV_ONE) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s, rx_shift_q[DATA_W-1:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + DIV_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == rx_div_q - DIV_ONE) begin
            rx_cnt_q <= '0;
            if (rx_s) begin
              rx_push_q  <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else begin
              rx_ferr_q  <= 1'b1;
              rx_state_q <= RX_BREAK;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + DIV_ONE;
          end
        end
        default: begin
          if (rx_s) rx_state_q <= RX_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_port_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_port_bridge : randomized self-checking bench with queue-based model|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_uart_port_bridge;
  localparam int CLK_DIV  = 434;
  localparam int DIV_W    = 16;
  localparam int RX_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rd = 1'b0;
  logic       uart_wr = 1'b0;
  logic [1:0] uart_addr = 2'd0;
  logic [7:0] uart_din = 8'h00;
  logic [7:0] uart_dout, uart_dout1;
  logic       rxd = 1'b1;
  logic       txd;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rxq[$];
  logic        m_ovr  = 1'b0;
  logic        m_ferr = 1'b0;
  logic [15:0] m_div  = 16'(CLK_DIV);

  always #5 clk = ~clk;

  uart_port_bridge #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W), .RX_DEPTH(RX_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rd    (uart_rd),
    .uart_wr    (uart_wr),
    .uart_addr  (uart_addr),
    .uart_din   (uart_din),
    .uart_dout  (uart_dout),
    .uart_dout1 (uart_dout1),
    .rxd        (rxd),
    .txd        (txd)
  );

  function automatic int eff_div();
    return (m_div < 16'd2) ? 2 : int'(m_div);
  endfunction

  function automatic logic [7:0] model_status();
    return {3'b000, m_ferr, m_ovr, rxq.size() == RX_DEPTH, rxq.size() != 0, 1'b1};
  endfunction

  function automatic logic [7:0] model_read(input logic [1:0] a);
    logic [7:0] v;
    case (a)
      2'd0: v = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
      2'd1: begin v = model_status(); m_ovr = 1'b0; m_ferr = 1'b0; end
      2'd2: v = m_div[7:0];
      default: v = m_div[15:8];
    endcase
    return v;
  endfunction

  function automatic void model_rx(input logic [7:0] b, input logic stop_bit);
    if (!stop_bit)                   m_ferr = 1'b1;
    else if (rxq.size() < RX_DEPTH) rxq.push_back(b);
    else                             m_ovr = 1'b1;
  endfunction

  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk); uart_wr = 1'b1; uart_addr = a; uart_din = d;
    @(negedge clk); uart_wr = 1'b0;
    if (a == 2'd2) m_div[7:0]  = d;
    if (a == 2'd3) m_div[15:8] = d;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk); uart_rd = 1'b1; uart_addr = a;
    @(negedge clk); uart_rd = 1'b0;
    d = uart_dout;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    int d;
    logic [9:0] fr;
    d  = eff_div();
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rxd = fr[i];
      repeat (d - 1) @(negedge clk);
    end
    @(negedge clk); rxd = 1'b1;
    repeat (2 * d + 6) @(negedge clk);
    model_rx(b, stop_bit);
  endtask

  // Transmits one byte and checks every bit period, the busy-write drop and tx_ready timing.
  task automatic run_tx_frame(input logic [7:0] b, input string tag);
    int d;
    logic [9:0] fr;
    logic bad, seen;
    d  = eff_div();
    fr = {1'b1, b, 1'b0};
    @(negedge clk); uart_wr = 1'b1; uart_addr = 2'd0; uart_din = b;
    @(negedge clk); uart_wr = 1'b0;
    checks++;
    if (uart_dout1[0] !== 1'b0)
      $display("FAIL %s tx_ready_drop: got %b expected 0", tag, uart_dout1[0]);
    for (int i = 0; i < 10; i++) begin
      bad = 1'b0; seen = fr[i];
      for (int c = 0; c < d; c++) begin
        if (txd !== fr[i]) begin bad = 1'b1; seen = txd; end
        if (i == 1 && c == 0) begin uart_wr = 1'b1; uart_din = ~b; end
        if (i == 1 && c == 1) uart_wr = 1'b0;
        @(negedge clk);
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s tx_bit%0d: got txd=%b expected %b (div %0d)", tag, i, seen, fr[i], d);
      end
    end
    checks++;
    if (uart_dout1[0] !== 1'b1) begin
      errors++;
      $display("FAIL %s tx_ready_back: got %b expected 1 at %0d cycles", tag, uart_dout1[0], 10 * d);
    end
    bad = 1'b0;
    repeat (12 * d) begin
      if (txd !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s tx_busy_write_dropped: got txd=0 expected idle 1", tag);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
    checks++;
    if (uart_dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", uart_dout); end
    checks++;
    if (uart_dout1 !== model_status()) begin
      errors++; $display("FAIL reset_status: got %h expected %h", uart_dout1, model_status());
    end
    for (int a = 2; a < 4; a++) begin
      reg_read(2'(a), v);
      checks++;
      if (v !== model_read(2'(a))) begin
        errors++; $display("FAIL reset_div_byte%0d: got %h expected %h", a, v, model_read(2'(a)));
      end
    end
  endtask

  task automatic test_tx();
    reg_write(2'd2, 8'd4);
    reg_write(2'd3, 8'd0);
    run_tx_frame(8'hA5, "tx_a5");
    for (int n = 0; n < 2; n++) begin
      reg_write(2'd2, 8'($urandom_range(3, 7)));
      run_tx_frame(8'($urandom), "tx_rand");
    end
  endtask

  task automatic test_rx();
    logic [7:0] v, e;
    int n;
    reg_write(2'd2, 8'd4);
    send_rx(8'h3C, 1'b1);
    checks++;
    if (uart_dout1 !== model_status()) begin
      errors++; $display("FAIL rx_avail_set: got %h expected %h", uart_dout1, model_status());
    end
    reg_read(2'd0, v); e = model_read(2'd0);
    checks++;
    if (v !== e) begin errors++; $display("FAIL rx_data_3c: got %h expected %h", v, e); end
    checks++;
    if (uart_dout1 !== model_status()) begin
      errors++; $display("FAIL rx_avail_clear: got %h expected %h", uart_dout1, model_status());
    end
    reg_write(2'd2, 8'($urandom_range(2, 8)));
    n = $urandom_range(1, RX_DEPTH);
    for (int i = 0; i < n; i++) send_rx(8'($urandom), 1'b1);
    for (int i = 0; i <= n; i++) begin
      reg_read(2'd0, v); e = model_read(2'd0);
      checks++;
      if (v !== e) begin errors++; $display("FAIL rx_rand_data%0d: got %h expected %h", i, v, e); end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] v, e;
    reg_write(2'd2, 8'd4);
    for (int i = 0; i <= RX_DEPTH; i++) send_rx(8'($urandom), 1'b1);
    checks++;
    if (uart_dout1 !== model_status()) begin
      errors++; $display("FAIL overrun_full_status: got %h expected %h", uart_dout1, model_status());
    end
    reg_read(2'd1, v); e = model_read(2'd1);
    checks++;
    if (v !== e) begin errors++; $display("FAIL overrun_status_read: got %h expected %h", v, e); end
    checks++;
    if (uart_dout1 !== model_status()) begin
      errors++; $display("FAIL overrun_cleared: got %h expected %h", uart_dout1, model_status());
    end
    for (int i = 0; i < RX_DEPTH; i++) begin
      reg_read(2'd0, v); e = model_read(2'd0);
      checks++;
      if (v !== e) begin errors++; $display("FAIL overrun_keep%0d: got %h expected %h", i, v, e); end
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] v, e;
    send_rx(8'($urandom), 1'b0);
    checks++;
    if (uart_dout1 !== model_status()) begin
      errors++; $display("FAIL frame_err_set: got %h expected %h", uart_dout1, model_status());
    end
    reg_read(2'd1, v); e = model_read(2'd1);
    checks++;
    if (v !== e) begin errors++; $display("FAIL frame_err_read: got %h expected %h", v, e); end
    checks++;
    if (uart_dout1 !== model_status()) begin
      errors++; $display("FAIL frame_err_cleared: got %h expected %h", uart_dout1, model_status());
    end
  endtask

  task automatic test_glitch();
    reg_write(2'd2, 8'd8);
    @(negedge clk); rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * eff_div() + 10) @(negedge clk);
    checks++;
    if (uart_dout1 !== model_status()) begin
      errors++; $display("FAIL glitch_ignored: got %h expected %h", uart_dout1, model_status());
    end
  endtask

  task automatic test_div_clamp();
    logic [7:0] v, e;
    reg_write(2'd2, 8'h01);
    reg_write(2'd3, 8'h00);
    for (int a = 2; a < 4; a++) begin
      reg_read(2'(a), v); e = model_read(2'(a));
      checks++;
      if (v !== e) begin errors++; $display("FAIL clamp_div_byte%0d: got %h expected %h", a, v, e); end
    end
    run_tx_frame(8'($urandom), "tx_clamp");
  endtask

  task automatic test_back_to_back();
    logic [7:0] v, e, nv;
    nv = 8'($urandom_range(2, 200));
    e  = model_read(2'd2);
    @(negedge clk); uart_rd = 1'b1; uart_wr = 1'b1; uart_addr = 2'd2; uart_din = nv;
    @(negedge clk); uart_rd = 1'b0; uart_wr = 1'b0;
    m_div[7:0] = nv;
    checks++;
    if (uart_dout !== e) begin errors++; $display("FAIL rdwr_old_value: got %h expected %h", uart_dout, e); end
    reg_read(2'd2, v); e = model_read(2'd2);
    checks++;
    if (v !== e) begin errors++; $display("FAIL rdwr_new_value: got %h expected %h", v, e); end
  endtask

  task automatic test_rst_mid();
    logic [7:0] v, e;
    reg_write(2'd2, 8'd4);
    reg_write(2'd3, 8'd0);
    send_rx(8'($urandom), 1'b1);
    reg_read(2'd2, v);
    @(negedge clk); uart_wr = 1'b1; uart_addr = 2'd0; uart_din = 8'hA5;
    @(negedge clk); uart_wr = 1'b0;
    repeat (17) @(negedge clk);
    checks++;
    if (txd !== 1'b0) begin errors++; $display("FAIL rst_mid_pre_bit3: got %b expected 0", txd); end
    #2 rst = 1'b0;
    rxq.delete(); m_ovr = 1'b0; m_ferr = 1'b0; m_div = 16'(CLK_DIV);
    #1;
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL rst_mid_txd: got %b expected 1", txd); end
    checks++;
    if (uart_dout1 !== model_status()) begin
      errors++; $display("FAIL rst_mid_status: got %h expected %h", uart_dout1, model_status());
    end
    checks++;
    if (uart_dout !== 8'h00) begin errors++; $display("FAIL rst_mid_dout: got %h expected 00", uart_dout); end
    @(negedge clk); @(negedge clk); rst = 1'b1;
    reg_read(2'd2, v); e = model_read(2'd2);
    checks++;
    if (v !== e) begin errors++; $display("FAIL rst_mid_div_restored: got %h expected %h", v, e); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_div_clamp();
    test_back_to_back();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
